// File: rtl/demorgan_sweep_checker_pkg.sv
// ---------------------------------------------------------------------------
// demorgan_pkg
//   Shared definitions for the 3-input NOR / De Morgan sweep checker.
//   - State encoding of the sweep FSM.
//   - Sweep geometry (number of vectors, vector and error-count widths).
//   - nor3_expected(): golden response of the stage under test.
// ---------------------------------------------------------------------------
package demorgan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t DRIVE = 2'd1;
  localparam state_t CHECK = 2'd2;
  localparam state_t DONE  = 2'd3;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;
  localparam int ERR_W       = 4;

  // Both F1 = NOR(A,B,C) and F2 = ~A & ~B & ~C must equal this value.
  function automatic logic nor3_expected(input logic [VEC_W-1:0] vec);
    return ~(vec[2] | vec[1] | vec[0]);
  endfunction

endpackage

// File: rtl/demorgan_sweep_checker_if.sv
// ---------------------------------------------------------------------------
// demorgan_sweep_checker_if
//   Connection between the sweep checker and the NOR / De Morgan stage.
//   a_o/b_o/c_o : stimulus, {a_o,b_o,c_o} = current vector
//   f1_i/f2_i   : stage responses, combinational from a_o/b_o/c_o
//   master : checker side (drives stimulus, reads responses)
//   slave  : stage side   (reads stimulus, drives responses)
//   There is no valid/ready handshake on this bus: the stimulus is a level
//   held for the settle window and the responses are only sampled in CHECK.
// ---------------------------------------------------------------------------
interface demorgan_sweep_checker_if;
  logic a_o;
  logic b_o;
  logic c_o;
  logic f1_i;
  logic f2_i;

  modport master (output a_o, b_o, c_o, input f1_i, f2_i);
  modport slave  (input a_o, b_o, c_o, output f1_i, f2_i);
endinterface

// File: rtl/demorgan_sweep_checker_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
//   Loadable down-counter used to hold a stimulus vector for a settle window.
//   clk, rst_n : clock, synchronous active-low reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one (ignored when already zero)
//   zero       : count == 0
// ---------------------------------------------------------------------------
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/demorgan_sweep_checker.sv
// ---------------------------------------------------------------------------
// demorgan_sweep_checker
//   Exhaustive stimulus/check controller for a 3-input NOR / De Morgan stage.
//   Walks vectors 0..7, holds each for SETTLE_CYCLES cycles, then samples both
//   stage outputs for one CHECK cycle and compares them to ~(A|B|C).
//   Parameters:
//     SETTLE_CYCLES : hold cycles per vector before sampling, legal 1..15
//   Ports:
//     clk, rst_n       : clock, synchronous active-low reset
//     start            : level; launches a sweep when sampled in IDLE or DONE
//     stage            : interface to the stage (stimulus out, responses in)
//     busy             : high in DRIVE/CHECK
//     done             : high in DONE, held until next launch or reset
//     pass             : done with zero errors
//     err_count        : failing vectors in current/last sweep (0..8)
//     first_fail_vec   : vector index of the first mismatch
//     first_fail_valid : a mismatch has been seen this sweep
//     state_o          : FSM state, for observation
// ---------------------------------------------------------------------------
module demorgan_sweep_checker
  import demorgan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  demorgan_sweep_checker_if.master stage,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERR_W-1:0]        err_count,
  output logic [VEC_W-1:0]        first_fail_vec,
  output logic                    first_fail_valid,
  output state_t                  state_o
);

  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [VEC_W-1:0]   ffv_q, ffv_d;
  logic               ffval_q, ffval_d;

  logic               launch;
  logic               mismatch;
  logic               last_vec;
  logic               timer_load;
  logic               timer_dec;
  logic               settle_zero;

  settle_timer #(.W(4)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_INIT),
    .dec      (timer_dec),
    .zero     (settle_zero)
  );

  // start is only honoured when no sweep is in flight; no queueing.
  assign launch   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_vec = (vec_q == LAST_VEC);

  // Two wrong outputs on the same vector still count as one failing vector.
  assign mismatch = (state_q == CHECK) &&
                    ((stage.f1_i != nor3_expected(vec_q)) ||
                     (stage.f2_i != nor3_expected(vec_q)));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = DRIVE;
      DRIVE:   if (settle_zero) state_d = CHECK;
      CHECK:   state_d = last_vec ? DONE : DRIVE;
      DONE:    if (launch) state_d = DRIVE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: vector counter, settle timer control, result registers
  always_comb begin
    vec_d      = vec_q;
    err_d      = err_q;
    ffv_d      = ffv_q;
    ffval_d    = ffval_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;

    if (launch) begin
      // A relaunch from DONE discards the previous results.
      vec_d      = '0;
      err_d      = '0;
      ffv_d      = '0;
      ffval_d    = 1'b0;
      timer_load = 1'b1;
    end else if (state_q == DRIVE) begin
      timer_dec = !settle_zero;
    end else if (state_q == CHECK) begin
      if (mismatch) begin
        err_d = err_q + ERR_W'(1);
        if (!ffval_q) begin
          ffv_d   = vec_q;
          ffval_d = 1'b1;
        end
      end
      // vec stays at 7 on the final CHECK so DONE keeps presenting it.
      if (!last_vec) begin
        vec_d      = vec_q + VEC_W'(1);
        timer_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q   <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
    end
  end

  // Outputs: all derived from registered state only, so glitch-free.
  always_comb begin
    busy             = (state_q == DRIVE) || (state_q == CHECK);
    done             = (state_q == DONE);
    pass             = (state_q == DONE) && (err_q == '0);
    err_count        = err_q;
    first_fail_vec   = ffv_q;
    first_fail_valid = ffval_q;
    state_o          = state_q;
    stage.a_o        = 1'b0;
    stage.b_o        = 1'b0;
    stage.c_o        = 1'b0;
    if (state_q != IDLE) begin
      stage.a_o = vec_q[2];
      stage.b_o = vec_q[1];
      stage.c_o = vec_q[0];
    end
  end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
module tb_demorgan_sweep_checker;

  // ------------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ------------------------------------------------------------------ DUTs
  // dut0 uses the default settle window, dut1 a window of one cycle.
  logic       start0, start1;
  logic       busy0, done0, pass0, ffval0;
  logic       busy1, done1, pass1, ffval1;
  logic [3:0] err0, err1;
  logic [2:0] ffv0, ffv1;
  logic [1:0] st0, st1;

  // Fault controls for the stage models: per-vector inversion masks and a stuck-at-0.
  logic [7:0] f1_flip0, f2_flip0, f1_flip1, f2_flip1;
  logic       f2_stuck0, f2_stuck1;

  demorgan_sweep_checker_if bus0();
  demorgan_sweep_checker_if bus1();

  assign bus0.f1_i = ~(bus0.a_o | bus0.b_o | bus0.c_o) ^ f1_flip0[{bus0.a_o, bus0.b_o, bus0.c_o}];
  assign bus0.f2_i = f2_stuck0 ? 1'b0 :
                     (~(bus0.a_o | bus0.b_o | bus0.c_o) ^ f2_flip0[{bus0.a_o, bus0.b_o, bus0.c_o}]);
  assign bus1.f1_i = ~(bus1.a_o | bus1.b_o | bus1.c_o) ^ f1_flip1[{bus1.a_o, bus1.b_o, bus1.c_o}];
  assign bus1.f2_i = f2_stuck1 ? 1'b0 :
                     (~(bus1.a_o | bus1.b_o | bus1.c_o) ^ f2_flip1[{bus1.a_o, bus1.b_o, bus1.c_o}]);

  demorgan_sweep_checker #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stage(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0), .state_o(st0)
  );

  demorgan_sweep_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stage(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1), .state_o(st1)
  );

  // ------------------------------------------------------------------ observation mux
  int         cur = 0;
  logic [2:0] o_abc;
  logic       o_busy, o_done, o_pass, o_ffval;
  logic [3:0] o_err;
  logic [2:0] o_ffv;
  logic [1:0] o_st;

  always_comb begin
    if (cur == 0) begin
      o_abc = {bus0.a_o, bus0.b_o, bus0.c_o}; o_busy = busy0; o_done = done0; o_pass = pass0;
      o_err = err0; o_ffv = ffv0; o_ffval = ffval0; o_st = st0;
    end else begin
      o_abc = {bus1.a_o, bus1.b_o, bus1.c_o}; o_busy = busy1; o_done = done1; o_pass = pass1;
      o_err = err1; o_ffv = ffv1; o_ffval = ffval1; o_st = st1;
    end
  end

  // ------------------------------------------------------------------ driver tasks
  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  // Reference model: walk the truth table and apply the stage faults.
  function automatic void model(input logic [7:0] m1, input logic [7:0] m2, input logic st,
                                output int errs, output int ffv, output bit ffok);
    errs = 0; ffv = 0; ffok = 0;
    for (int v = 0; v < 8; v++) begin
      bit e, o1, o2;
      e  = (v == 0);
      o1 = e ^ m1[v];
      o2 = st ? 1'b0 : (e ^ m2[v]);
      if ((o1 != e) || (o2 != e)) begin
        errs++;
        if (!ffok) begin ffok = 1; ffv = v; end
      end
    end
  endfunction

  // Launch one sweep and check every cycle until done; mid_idx >= 0 injects
  // a one-cycle start pulse at that cycle, which must be ignored.
  task automatic run_sweep(input int sel, input int s, input int mid_idx, input string tag);
    int  per, total, errs, ffv;
    bit  ffok;
    logic [2:0] e_abc;
    logic e_busy, e_done;
    if (sel == 0) model(f1_flip0, f2_flip0, f2_stuck0, errs, ffv, ffok);
    else          model(f1_flip1, f2_flip1, f2_stuck1, errs, ffv, ffok);
    cur   = sel;
    per   = s + 1;
    total = 8 * per;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1 set_start(sel, 1'b0);
    for (int i = 0; i <= total; i++) begin
      @(negedge clk);
      if (i == mid_idx + 1) set_start(sel, 1'b0);
      e_abc  = (i < total) ? 3'(i / per) : 3'd7;
      e_busy = (i < total);
      e_done = (i == total);
      n_cmp++;
      if ({o_abc, o_busy, o_done} !== {e_abc, e_busy, e_done}) begin
        n_fail++;
        $display("FAIL %s seq cycle %0d: got abc=%0d busy=%0b done=%0b, expected abc=%0d busy=%0b done=%0b",
                 tag, i, o_abc, o_busy, o_done, e_abc, e_busy, e_done);
      end
      if (i == mid_idx) set_start(sel, 1'b1);
    end
    n_cmp++;
    if (o_err !== 4'(errs)) begin
      n_fail++;
      $display("FAIL %s err_count: got %0d, expected %0d", tag, o_err, errs);
    end
    n_cmp++;
    if (o_ffval !== ffok) begin
      n_fail++;
      $display("FAIL %s first_fail_valid: got %0b, expected %0b", tag, o_ffval, ffok);
    end
    n_cmp++;
    if (o_ffv !== 3'(ffv)) begin
      n_fail++;
      $display("FAIL %s first_fail_vec: got %0d, expected %0d", tag, o_ffv, ffv);
    end
    n_cmp++;
    if (o_pass !== (errs == 0)) begin
      n_fail++;
      $display("FAIL %s pass: got %0b, expected %0b", tag, o_pass, (errs == 0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({o_abc, o_busy, o_done, o_pass, o_err, o_ffv, o_ffval, o_st} !== 16'h0) begin
      n_fail++;
      $display("FAIL %s: got abc=%0d busy=%0b done=%0b pass=%0b err=%0d ffv=%0d ffval=%0b state=%0d, expected all 0",
               tag, o_abc, o_busy, o_done, o_pass, o_err, o_ffv, o_ffval, o_st);
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cur = 0; #1 check_all_zero("reset dut0");
    cur = 1; #1 check_all_zero("reset dut1");
    rst_n = 1'b1;
  endtask

  task automatic test_ideal();
    f1_flip0 = '0; f2_flip0 = '0; f2_stuck0 = 1'b0;
    run_sweep(0, 2, -1, "ideal");
  endtask

  task automatic test_f2_stuck();
    f1_flip0 = '0; f2_flip0 = '0; f2_stuck0 = 1'b1;
    run_sweep(0, 2, -1, "f2_stuck0");
    f2_stuck0 = 1'b0;
  endtask

  task automatic test_f1_inv_5_6();
    f1_flip0 = 8'b0110_0000; f2_flip0 = '0; f2_stuck0 = 1'b0;
    run_sweep(0, 2, -1, "f1_inv_5_6");
    f1_flip0 = '0;
  endtask

  task automatic test_reset_mid();
    cur = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int i = 0; i <= 12; i++) @(negedge clk);
    n_cmp++;
    if ({o_abc, o_busy, o_st} !== {3'd4, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL reset_mid pre: got abc=%0d busy=%0b state=%0d, expected abc=4 busy=1 state=1",
               o_abc, o_busy, o_st);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid post");
    rst_n = 1'b1;
    run_sweep(0, 2, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    bit seen;
    // Mid-sweep start pulse is ignored; f2 stuck leaves one error to be cleared.
    f2_stuck0 = 1'b1;
    run_sweep(0, 2, 5, "busy_start");
    cur    = 0;
    start0 = 1'b1;
    for (int j = 0; j <= 25; j++) begin
      @(negedge clk);
      n_cmp++;
      if (j < 24) begin
        if ({o_busy, o_done, o_abc} !== {1'b1, 1'b0, 3'(j / 3)}) begin
          n_fail++;
          $display("FAIL soak cycle %0d: got busy=%0b done=%0b abc=%0d, expected busy=1 done=0 abc=%0d",
                   j, o_busy, o_done, o_abc, j / 3);
        end
      end else if (j == 24) begin
        if ({o_done, o_pass, o_err} !== {1'b1, 1'b0, 4'd1}) begin
          n_fail++;
          $display("FAIL soak done: got done=%0b pass=%0b err=%0d, expected done=1 pass=0 err=1",
                   o_done, o_pass, o_err);
        end
      end else begin
        if ({o_busy, o_done, o_err, o_ffval, o_abc} !== {1'b1, 1'b0, 4'd0, 1'b0, 3'd0}) begin
          n_fail++;
          $display("FAIL soak relaunch: got busy=%0b done=%0b err=%0d ffval=%0b abc=%0d, expected 1 0 0 0 0",
                   o_busy, o_done, o_err, o_ffval, o_abc);
        end
      end
      if (j == 0) begin
        n_cmp++;
        if ({o_err, o_ffval} !== 5'd0) begin
          n_fail++;
          $display("FAIL soak clear: got err=%0d ffval=%0b, expected err=0 ffval=0", o_err, o_ffval);
        end
      end
    end
    start0    = 1'b0;
    f2_stuck0 = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (o_done) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL soak drain: done not seen within 40 cycles, expected done=1");
    end
  endtask

  task automatic test_settle1();
    f1_flip1 = 8'b0000_1000; f2_flip1 = 8'b0000_1000; f2_stuck1 = 1'b0;
    run_sweep(1, 1, -1, "settle1_vec3");
    f1_flip1 = '0; f2_flip1 = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      if (n < 4) begin
        f1_flip0  = 8'($urandom_range(0, 255));
        f2_flip0  = 8'($urandom_range(0, 255));
        f2_stuck0 = ($urandom_range(0, 3) == 0);
        run_sweep(0, 2, int'($urandom_range(1, 20)), "rand0");
      end else begin
        f1_flip1  = 8'($urandom_range(0, 255));
        f2_flip1  = 8'($urandom_range(0, 255));
        f2_stuck1 = ($urandom_range(0, 3) == 0);
        run_sweep(1, 1, int'($urandom_range(1, 12)), "rand1");
      end
    end
  endtask

  // ------------------------------------------------------------------ sequence + report
  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    f1_flip0 = '0; f2_flip0 = '0; f2_stuck0 = 1'b0;
    f1_flip1 = '0; f2_flip1 = '0; f2_stuck1 = 1'b0;
    test_reset();
    test_ideal();
    test_f2_stuck();
    test_f1_inv_5_6();
    test_reset_mid();
    test_back_to_back();
    test_settle1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
